// File: rtl/mem_arbiter_if.sv
// Request/acknowledge bundle between the CPU and debug requesters, the arbiter and the
// single-port RAM. The slave modport is the arbiter; the master modport is everything around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              in_cpu_req;
  logic              in_cpu_we;
  logic [ADDR_W-1:0] in_cpu_addr;
  logic [DATA_W-1:0] in_cpu_wdata;
  logic              out_cpu_ack;
  logic [DATA_W-1:0] out_cpu_rdata;

  logic              in_dbg_req;
  logic              in_dbg_we;
  logic [ADDR_W-1:0] in_dbg_addr;
  logic [DATA_W-1:0] in_dbg_wdata;
  logic              out_dbg_ack;
  logic [DATA_W-1:0] out_dbg_rdata;

  logic [ADDR_W-1:0] out_mem_address;
  logic [DATA_W-1:0] out_mem_data;
  logic              out_mem_rden;
  logic              out_mem_wren;
  logic [DATA_W-1:0] in_mem_q;

  logic              out_busy;
  logic              out_owner;

  modport slave (
    input  in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata,
    output out_cpu_ack, out_cpu_rdata,
    input  in_dbg_req, in_dbg_we, in_dbg_addr, in_dbg_wdata,
    output out_dbg_ack, out_dbg_rdata,
    output out_mem_address, out_mem_data, out_mem_rden, out_mem_wren,
    input  in_mem_q,
    output out_busy, out_owner
  );

  modport master (
    output in_cpu_req, in_cpu_we, in_cpu_addr, in_cpu_wdata,
    input  out_cpu_ack, out_cpu_rdata,
    output in_dbg_req, in_dbg_we, in_dbg_addr, in_dbg_wdata,
    input  out_dbg_ack, out_dbg_rdata,
    input  out_mem_address, out_mem_data, out_mem_rden, out_mem_wren,
    output in_mem_q,
    input  out_busy, out_owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// CPU/debug arbiter for the single-port RAM: 4-cycle IDLE/ISSUE/WAIT/DONE access, one-cycle ack;
// requesters hold req until ack. MEM_ARB_STARVE_EN lets debug win after MAX_HOLD straight CPU grants.
module mem_arbiter #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_arbiter_if.slave       bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int CNT_W = ($clog2(MAX_HOLD + 1) > 3) ? $clog2(MAX_HOLD + 1) : 3;

`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic [1:0]        state;
  logic              we_q;
  logic              owner_q;
  logic              cpu_ack_q;
  logic              dbg_ack_q;
  logic              rden_q;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic [CNT_W-1:0]  hold_cnt;
  logic              hold_full;
  logic              any_req;
  logic              dbg_win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  assign any_req   = bus.in_cpu_req | bus.in_dbg_req;
  assign hold_full = (hold_cnt == CNT_W'(MAX_HOLD));
  // Debug takes the slot when it is alone, or when the guard has saturated.
  assign dbg_win   = bus.in_dbg_req & (~bus.in_cpu_req | (STARVE_EN & hold_full));

  always_comb begin
    win_we    = bus.in_cpu_we;
    win_addr  = bus.in_cpu_addr;
    win_wdata = bus.in_cpu_wdata;
    if (dbg_win) begin
      win_we    = bus.in_dbg_we;
      win_addr  = bus.in_dbg_addr;
      win_wdata = bus.in_dbg_wdata;
    end
  end

`ifdef MEM_ARB_STARVE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (!bus.in_dbg_req || dbg_win)
        hold_cnt <= '0;
      else if (bus.in_cpu_req && !hold_full)
        hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  assign hold_cnt = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner_q <= dbg_win;
            we_q    <= win_we;
            addr_q  <= win_addr;
            data_q  <= win_wdata;
            rden_q  <= ~win_we;
            wren_q  <= win_we;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rden_q <= 1'b0;
          wren_q <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // RAM output registered at the end of ISSUE is valid throughout this cycle.
          if (!we_q) begin
            if (owner_q) dbg_rdata_q <= bus.in_mem_q;
            else         cpu_rdata_q <= bus.in_mem_q;
          end
          if (owner_q) dbg_ack_q <= 1'b1;
          else         cpu_ack_q <= 1'b1;
          state <= ST_DONE;
        end
        default: begin
          cpu_ack_q <= 1'b0;
          dbg_ack_q <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_cpu_ack     = cpu_ack_q;
  assign bus.out_dbg_ack     = dbg_ack_q;
  assign bus.out_cpu_rdata   = cpu_rdata_q;
  assign bus.out_dbg_rdata   = dbg_rdata_q;
  assign bus.out_mem_address = addr_q;
  assign bus.out_mem_data    = data_q;
  assign bus.out_mem_rden    = rden_q;
  assign bus.out_mem_wren    = wren_q;
  assign bus.out_busy        = (state != ST_IDLE);
  assign bus.out_owner       = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-output RAM model; inputs change and outputs
// are sampled on the falling edge. Define MEM_ARB_STARVE_EN to exercise the starvation guard.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_HOLD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] ram [0:511];
  always @(posedge clk) begin
    if (bus.out_mem_wren) ram[bus.out_mem_address] <= bus.out_mem_data;
    if (bus.out_mem_rden) bus.in_mem_q <= ram[bus.out_mem_address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input bit dbg, input bit req, input bit we,
                          input logic [8:0] a, input logic [31:0] wd);
    if (dbg) begin
      bus.in_dbg_req = req; bus.in_dbg_we = we; bus.in_dbg_addr = a; bus.in_dbg_wdata = wd;
    end else begin
      bus.in_cpu_req = req; bus.in_cpu_we = we; bus.in_cpu_addr = a; bus.in_cpu_wdata = wd;
    end
  endtask

  // Single transaction from an idle arbiter; returns at the falling edge after DONE.
  task automatic txn(input bit dbg, input bit we, input logic [8:0] a,
                     input logic [31:0] wd, input string tag, output logic [31:0] rd);
    int n;
    bit seen;
    set_port(dbg, 1'b1, we, a, wd);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check({tag, "_en"}, {30'd0, bus.out_mem_rden, bus.out_mem_wren}, {30'd0, ~we, we});
        check({tag, "_addr"}, {23'd0, bus.out_mem_address}, {23'd0, a});
        check({tag, "_owner"}, {31'd0, bus.out_owner}, {31'd0, dbg});
      end
      if (n == 2)
        check({tag, "_en_off"}, {30'd0, bus.out_mem_rden, bus.out_mem_wren}, 32'd0);
      seen = dbg ? bus.out_dbg_ack : bus.out_cpu_ack;
    end
    check({tag, "_lat"}, n, 32'd3);
    rd = dbg ? bus.out_dbg_rdata : bus.out_cpu_rdata;
    set_port(dbg, 1'b0, 1'b0, 9'd0, 32'd0);
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, bus.out_busy, (bus.out_cpu_ack | bus.out_dbg_ack)}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    int cpu_at [$];
    int dbg_at [$];

    reset = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 9'd0, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 9'd0, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Reset / idle
    @(negedge clk);
    check("rst_ctrl", {26'd0, bus.out_busy, bus.out_owner, bus.out_mem_rden, bus.out_mem_wren,
                       bus.out_cpu_ack, bus.out_dbg_ack}, 32'd0);
    check("rst_addr", {23'd0, bus.out_mem_address}, 32'd0);
    check("rst_data", bus.out_mem_data, 32'd0);
    check("rst_cpu_rdata", bus.out_cpu_rdata, 32'd0);
    check("rst_dbg_rdata", bus.out_dbg_rdata, 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_hold", {28'd0, bus.out_busy, bus.out_mem_rden, bus.out_mem_wren,
                          bus.out_cpu_ack | bus.out_dbg_ack}, 32'd0);
    end

    // CPU write then read back
    txn(1'b0, 1'b1, 9'h1A5, 32'hDEADBEEF, "cpu_wr", rd);
    txn(1'b0, 1'b0, 9'h1A5, 32'h0, "cpu_rd", rd);
    check("cpu_rd_data", rd, 32'hDEADBEEF);

    // Debug preload
    txn(1'b1, 1'b1, 9'h010, 32'h1010_0010, "dbg_wr10", rd);
    txn(1'b1, 1'b1, 9'h020, 32'h2020_0020, "dbg_wr20", rd);
    txn(1'b1, 1'b1, 9'h005, 32'h0000_0011, "dbg_wr05", rd);
    txn(1'b1, 1'b1, 9'h006, 32'h0000_0066, "dbg_wr06", rd);

    // Simultaneous reads: CPU first, debug exactly four cycles later
    set_port(1'b0, 1'b1, 1'b0, 9'h010, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 9'h020, 32'h0);
    cpu_at = {};
    dbg_at = {};
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) check("sim_owner_cpu", {31'd0, bus.out_owner}, 32'd0);
      if (n == 5) check("sim_owner_dbg", {31'd0, bus.out_owner}, 32'd1);
      if (bus.out_cpu_ack) begin
        cpu_at.push_back(n);
        check("sim_cpu_rdata", bus.out_cpu_rdata, 32'h1010_0010);
        bus.in_cpu_req = 1'b0;
      end
      if (bus.out_dbg_ack) begin
        dbg_at.push_back(n);
        check("sim_dbg_rdata", bus.out_dbg_rdata, 32'h2020_0020);
        bus.in_dbg_req = 1'b0;
      end
    end
    check("sim_cpu_acks", cpu_at.size(), 32'd1);
    check("sim_dbg_acks", dbg_at.size(), 32'd1);
    if (cpu_at.size() == 1) check("sim_cpu_at", cpu_at[0], 32'd3);
    if (dbg_at.size() == 1) check("sim_dbg_at", dbg_at[0], 32'd7);

    // Hold: debug rdata stays put across a CPU read
    txn(1'b1, 1'b0, 9'h005, 32'h0, "dbg_rd05", rd);
    check("dbg_rd05_data", rd, 32'h11);
    set_port(1'b0, 1'b1, 1'b0, 9'h006, 32'h0);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check("hold_dbg_rdata", bus.out_dbg_rdata, 32'h11);
      if (n == 3) begin
        check("hold_cpu_ack", {31'd0, bus.out_cpu_ack}, 32'd1);
        check("hold_cpu_rdata", bus.out_cpu_rdata, 32'h66);
        bus.in_cpu_req = 1'b0;
      end
    end

    // Reset during WAIT of a debug read
    set_port(1'b1, 1'b1, 1'b0, 9'h020, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", {31'd0, bus.out_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_ctrl", {26'd0, bus.out_busy, bus.out_owner, bus.out_mem_rden, bus.out_mem_wren,
                           bus.out_cpu_ack, bus.out_dbg_ack}, 32'd0);
    check("mid_rst_addr", {23'd0, bus.out_mem_address}, 32'd0);
    check("mid_rst_dbg_rdata", bus.out_dbg_rdata, 32'd0);
    check("mid_rst_cpu_rdata", bus.out_cpu_rdata, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("mid_rst_no_ack", {31'd0, bus.out_dbg_ack}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    txn(1'b1, 1'b0, 9'h020, 32'h0, "reissue", rd);
    check("reissue_data", rd, 32'h2020_0020);

    // Continuous CPU traffic with debug pending
    set_port(1'b0, 1'b1, 1'b0, 9'h010, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 9'h020, 32'h0);
    cpu_at = {};
    dbg_at = {};
`ifdef MEM_ARB_STARVE_EN
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (bus.out_cpu_ack) cpu_at.push_back(n);
      if (bus.out_dbg_ack) begin
        dbg_at.push_back(n);
        bus.in_dbg_req = 1'b0;
      end
    end
    check("starve_cpu_acks", cpu_at.size(), 32'd5);
    check("starve_dbg_acks", dbg_at.size(), 32'd1);
    if (dbg_at.size() == 1) check("starve_dbg_at", dbg_at[0], 32'd19);
    if (cpu_at.size() == 5) begin
      check("starve_cpu4_at", cpu_at[3], 32'd15);
      check("starve_cpu_resume", cpu_at[4], 32'd23);
    end
`else
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.out_cpu_ack) cpu_at.push_back(n);
      if (bus.out_dbg_ack) dbg_at.push_back(n);
    end
    check("strict_cpu_acks", cpu_at.size(), 32'd25);
    check("strict_dbg_acks", dbg_at.size(), 32'd0);
`endif
    set_port(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    @(negedge clk);
    check("final_idle", {31'd0, bus.out_busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port 512-word program/data RAM between two requesters: the CPU memory path (MAR/MDR, driven by the control unit) and a debug/loader port used to preload or inspect memory. Requests are sequenced through a four-state FSM that drives the RAM's address, data, rden and wren, captures read data, and returns a one-cycle acknowledge. It sits between `datapath`/`control_unit` and `memory` in `system`.

## Interface
Parameters:
- ADDR_W, 9, RAM address width
- DATA_W, 32, RAM data width
- MAX_HOLD, 4, consecutive CPU grants allowed while debug is pending (used only with MEM_ARB_STARVE_EN)

Ports:
- clk  input  1  system clock (divided clock); all state changes on rising edge
- reset  input  1  asynchronous, active-low reset
- in_cpu_req / in_dbg_req  input  1  access request; held until ack
- in_cpu_we / in_dbg_we  input  1  1 = write, 0 = read
- in_cpu_addr / in_dbg_addr  input  ADDR_W  word address
- in_cpu_wdata / in_dbg_wdata  input  DATA_W  write data
- out_cpu_ack / out_dbg_ack  output  1  one-cycle completion pulse
- out_cpu_rdata / out_dbg_rdata  output  DATA_W  read data, valid while ack high, held until that port's next read completes
- out_mem_address  output  ADDR_W  RAM address
- out_mem_data  output  DATA_W  RAM write data
- out_mem_rden / out_mem_wren  output  1  RAM read/write enables
- in_mem_q  input  DATA_W  RAM read data (valid the cycle after the RAM samples rden)
- out_busy  output  1  high in ISSUE, WAIT, DONE
- out_owner  output  1  0 = CPU, 1 = debug; meaningful only while out_busy

## Operation
- States: IDLE → ISSUE → WAIT → DONE → IDLE; no other transitions except reset.
- IDLE: requests sampled only here. If any request is high, pick winner, register addr/wdata/we/owner, drive out_mem_rden = ~we or out_mem_wren = we; go to ISSUE. Else stay.
- ISSUE: enables high for exactly this cycle; RAM samples at the closing edge. Go to WAIT.
- WAIT: enables low. At closing edge, for a read, load in_mem_q into the owner's rdata register; set the owner's ack; go to DONE.
- DONE: owner's ack high for this cycle only. Requests are ignored. Go to IDLE.
- Requester rule: drop (or change) req on the same edge that samples ack high; a req still high in the following IDLE is a new transaction.
- Arbitration: both requests high → CPU wins, unless the starvation guard fires (see Configuration).
- Guard counter (3 bits min, saturating at MAX_HOLD): increments on each CPU grant while in_dbg_req is high; clears on any debug grant or when in_dbg_req is low in IDLE.
- out_mem_address/out_mem_data stay at their last values outside ISSUE; only the enables are qualified.

## Timing
- Reset (asynchronous, reset = 0): state IDLE; all acks, enables, out_busy, out_owner = 0; rdata registers, mem address/data = 0; guard counter = 0. An in-flight transaction is abandoned with no ack; the requester must reissue. A wren pulse is cut immediately.
- Latency: request sampled at edge E0 → enable high E0–E1 → ack high E2–E3 → IDLE at E3. Four cycles per access; next access is sampled at E4 earliest.
- Throughput: one access per four cycles, read or write.
- Reads and writes follow identical timing; write ack means the RAM has sampled the write.
- Request and req-change mid-transaction (ISSUE/WAIT/DONE) are ignored; the latched values are used.

## Configuration
- MEM_ARB_STARVE_EN defined: when both requests are high in IDLE and the guard counter equals MAX_HOLD, debug wins instead of CPU.
- Not defined: strict CPU priority; the guard counter is not built and debug can starve indefinitely under continuous CPU traffic.

## Test plan
- Reset/idle: hold reset low, raise it, no requests → all outputs 0, state stays IDLE for 20 cycles.
- CPU write then read: write 0xDEADBEEF to addr 0x1A5, then read 0x1A5 → wren pulses one cycle at E0–E1, read ack at E2 with out_cpu_rdata = 0xDEADBEEF, 4 cycles each.
- Simultaneous requests: CPU reads 0x010, debug reads 0x020 in same cycle → CPU acked first, debug acked exactly 4 cycles later; out_owner 0 then 1.
- Starvation (MEM_ARB_STARVE_EN, MAX_HOLD = 4): CPU requests continuously, debug held high → 4 CPU acks, then debug ack, then CPU resumes; without macro, no debug ack in 100 cycles.
- Reset mid-operation: assert reset during WAIT of a debug read → no ack, outputs 0 immediately; reissued read completes normally with correct data.
- Hold behaviour: read 0x005 (= 0x11) by debug, then CPU read of 0x006 → out_dbg_rdata stays 0x11 throughout the CPU transaction.
